// File: rtl/data_cache_ctrl.sv
// Miss-handling controller in front of data_cache: lookup, dirty-victim
// writeback, 4-beat write-allocate refill, then replay of the original access.
module data_cache_ctrl #(
    parameter int LINE_BEATS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_req_we,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [127:0]      cpu_req_wdata,
    output logic              cpu_resp_valid,
    output logic [127:0]      cpu_resp_rdata,
    output logic              c_r,
    output logic              c_w,
    output logic [7:0]        c_index,
    output logic [17:0]       c_tag,
    output logic [5:0]        c_line,
    output logic [127:0]      c_w_data,
    output logic [1:0]        c_w_way,
    output logic              c_w_tagcheck,
    input  logic              c_hit,
    input  logic              c_dirty,
    input  logic [1:0]        c_way,
    input  logic [17:0]       c_tag_out,
    input  logic [127:0]      c_data_out,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [127:0]      mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [127:0]      mem_resp_rdata
);
    localparam int BW = $clog2(LINE_BEATS);
    localparam logic [BW-1:0] LAST = BW'(LINE_BEATS - 1);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, RESP, WB_RD, WB_REQ, FILL_REQ, FILL_WAIT, REPLAY
    } state_t;

    state_t state, next;

    logic [BW-1:0] beat;
    logic          req_we;
    logic [17:0]   req_tag;
    logic [7:0]    req_index;
    logic [1:0]    req_chunk;
    logic [127:0]  req_wdata;
    logic [1:0]    vway;
    logic [17:0]   vtag;
    logic [127:0]  rdata_q;
    logic          wb_fresh;
    logic [127:0]  wb_data_q;
    logic          accept;
    logic          unused_bits;

    assign unused_bits   = ^cpu_req_addr[3:0];
    // Ready is masked by rst so every output reads 0 while reset is held.
    assign cpu_req_ready = (state == IDLE) && !rst;
    assign accept        = cpu_req_valid && cpu_req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat      <= '0;
            req_we    <= 1'b0;
            req_tag   <= '0;
            req_index <= '0;
            req_chunk <= '0;
            req_wdata <= '0;
            vway      <= '0;
            vtag      <= '0;
            rdata_q   <= '0;
            wb_fresh  <= 1'b0;
            wb_data_q <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    req_we    <= cpu_req_we;
                    req_tag   <= cpu_req_addr[ADDR_W-1:14];
                    req_index <= cpu_req_addr[13:6];
                    req_chunk <= cpu_req_addr[5:4];
                    req_wdata <= cpu_req_wdata;
                end
                LOOKUP: if (c_hit) begin
                    rdata_q <= req_we ? '0 : c_data_out;
                end else begin
                    vway <= c_way;
                    vtag <= c_tag_out;
                    beat <= '0;
                end
                WB_RD: wb_fresh <= 1'b1;
                WB_REQ: begin
                    // Capture the victim chunk so it stays put while memory stalls.
                    if (wb_fresh) begin
                        wb_data_q <= c_data_out;
                        wb_fresh  <= 1'b0;
                    end
                    if (mem_req_ready) beat <= beat + BW'(1);
                end
                FILL_WAIT: if (mem_resp_valid) beat <= beat + BW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        next           = state;
        cpu_resp_valid = 1'b0;
        cpu_resp_rdata = '0;
        c_r            = 1'b0;
        c_w            = 1'b0;
        c_index        = '0;
        c_tag          = '0;
        c_line         = '0;
        c_w_data       = '0;
        c_w_way        = '0;
        c_w_tagcheck   = 1'b0;
        mem_req_valid  = 1'b0;
        mem_req_we     = 1'b0;
        mem_req_addr   = '0;
        mem_req_wdata  = '0;
        unique case (state)
            IDLE: if (accept) begin
                c_r     = 1'b1;
                c_index = cpu_req_addr[13:6];
                c_tag   = cpu_req_addr[ADDR_W-1:14];
                c_line  = {cpu_req_addr[5:4], 4'b0000};
                next    = LOOKUP;
            end
            LOOKUP: begin
                if (c_hit) begin
                    if (req_we) begin
                        c_w          = 1'b1;
                        c_w_way      = c_way;
                        c_w_tagcheck = 1'b1;
                        c_index      = req_index;
                        c_tag        = req_tag;
                        c_line       = {req_chunk, 4'b0000};
                        c_w_data     = req_wdata;
                    end
                    next = RESP;
                end else begin
                    next = c_dirty ? WB_RD : FILL_REQ;
                end
            end
            RESP: begin
                cpu_resp_valid = 1'b1;
                cpu_resp_rdata = rdata_q;
                next           = IDLE;
            end
            WB_RD: begin
                c_r     = 1'b1;
                c_index = req_index;
                c_tag   = vtag;
                c_line  = {beat, 4'b0000};
                next    = WB_REQ;
            end
            WB_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {vtag, req_index, beat, 4'b0000};
                mem_req_wdata = wb_fresh ? c_data_out : wb_data_q;
                if (mem_req_ready)
                    next = (beat == LAST) ? FILL_REQ : WB_RD;
            end
            FILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_tag, req_index, beat, 4'b0000};
                if (mem_req_ready) next = FILL_WAIT;
            end
            FILL_WAIT: if (mem_resp_valid) begin
                c_w      = 1'b1;
                c_w_way  = vway;
                c_index  = req_index;
                c_tag    = req_tag;
                c_line   = {beat, 4'b0000};
                c_w_data = mem_resp_rdata;
                next     = (beat == LAST) ? REPLAY : FILL_REQ;
            end
            REPLAY: begin
                c_r     = 1'b1;
                c_index = req_index;
                c_tag   = req_tag;
                c_line  = {req_chunk, 4'b0000};
                next    = LOOKUP;
            end
            default: next = IDLE;
        endcase
    end
endmodule
